// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Reset distribution for the quadrature decoder datapath. The raw board
//   reset is synchronised (async assert, sync deassert, 2 flops), then
//   NUM_STAGES downstream reset domains are released in ascending order,
//   STAGE_DELAY clocks apart.
//
//   Optional feature, macro RESET_SEQUENCER_SOFT_RESET_EN: a host may
//   request a timed soft reset of all stages (SOFT_HOLD clocks) by a rising
//   edge on sw_rst_req while the sequencer is in RUN; sw_rst_ack pulses for
//   one cycle when the hold ends. Without the macro sw_rst_req is ignored
//   and sw_rst_ack is tied low.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   raw reset, asynchronous, active-high
//   sw_rst_req  in   soft reset request (level, edge-detected internally)
//   sw_rst_ack  out  one-cycle pulse when the soft-reset hold completes
//   stage_rst   out  [NUM_STAGES] active-high reset per stage, bit 0 first
//   all_ready   out  every stage is out of reset
//   seq_busy    out  sequencer is in any state other than RUN
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 4,
  parameter int SOFT_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_rst_req,
  output logic                  sw_rst_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_ready,
  output logic                  seq_busy
);

  localparam int MAX_DLY = (STAGE_DELAY > SOFT_HOLD) ? STAGE_DELAY : SOFT_HOLD;
  localparam int CNT_W   = $clog2(MAX_DLY + 1);
  localparam int IDX_W   = $clog2(NUM_STAGES) + 1;

`ifdef RESET_SEQUENCER_SOFT_RESET_EN
  typedef enum logic [1:0] {HOLD, RELEASE, RUN, SOFT} state_t;
`else
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
`endif

  state_t                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  all_ready_q, all_ready_d;
  logic                  ack_q, ack_d;
  logic                  req_q, req_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HOLD;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
      all_ready_q <= 1'b0;
      ack_q       <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_rst_q <= stage_rst_d;
      all_ready_q <= all_ready_d;
      ack_q       <= ack_d;
      req_q       <= req_d;
    end
  end

`ifdef RESET_SEQUENCER_SOFT_RESET_EN
  assign req_d = sw_rst_req;
`else
  logic unused_req;
  assign unused_req = sw_rst_req;
  assign req_d      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], 1'b0};
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stage_rst_d = stage_rst_q;
    all_ready_d = all_ready_q;
    ack_d       = 1'b0;

    case (state_q)
      HOLD: begin
        stage_rst_d = '1;
        all_ready_d = 1'b0;
        if (!sync_q[1]) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      RELEASE: begin
        if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          // Loop compare avoids indexing stage_rst with an over-wide index.
          for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == IDX_W'(i)) stage_rst_d[i] = 1'b0;
          end
          if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
            state_d     = RUN;
            all_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
        stage_rst_d = '0;
        all_ready_d = 1'b1;
`ifdef RESET_SEQUENCER_SOFT_RESET_EN
        // req_q samples in every state, so a level held since RELEASE
        // presents no rising edge here.
        if (sw_rst_req && !req_q) begin
          state_d     = SOFT;
          cnt_d       = '0;
          stage_rst_d = '1;
          all_ready_d = 1'b0;
        end
`endif
      end

`ifdef RESET_SEQUENCER_SOFT_RESET_EN
      SOFT: begin
        stage_rst_d = '1;
        all_ready_d = 1'b0;
        if (cnt_q == CNT_W'(SOFT_HOLD - 1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      default: state_d = HOLD;
    endcase
  end

  assign stage_rst  = stage_rst_q;
  assign all_ready  = all_ready_q;
  assign seq_busy   = (state_q != RUN);
  assign sw_rst_ack = ack_q;

endmodule
